// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, scan position, syncs, visible flag, line/frame pulses, frame counter.
// Defining VGA_PREFETCH_EN presents h_cnt/v_cnt one pixel ahead of the syncs/valid/pulses.
module vga_timing_gen #(
  parameter int PIX_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_stb,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  // Raster step: h wraps at the end of the line and carries into v.
  function automatic logic [19:0] advance(input logic [9:0] v, input logic [9:0] h);
    logic [9:0] hn;
    logic [9:0] vn;
    hn = (h == H_LAST) ? 10'd0 : h + 10'd1;
    vn = v;
    if (h == H_LAST) begin
      vn = (v == V_LAST) ? 10'd0 : v + 10'd1;
    end
    return {vn, hn};
  endfunction

  logic [3:0]  div_q, div_d;
  logic        tick;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [9:0]  h_nxt, v_nxt;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        valid_q, valid_d;
  logic        pix_stb_q, pix_stb_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
`ifdef VGA_PREFETCH_EN
  logic [9:0]  h_pf_q, h_pf_d, v_pf_q, v_pf_d;
`endif

  assign tick = (div_q == DIV_LAST);

  // Everything derived from the position is computed from the upcoming pixel so it
  // lands in the same register update as the position itself.
  always_comb begin
    {v_nxt, h_nxt} = advance(v_q, h_q);
    div_d          = tick ? 4'd0 : div_q + 4'd1;
    h_d            = h_q;
    v_d            = v_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    valid_d        = valid_q;
    pix_stb_d      = 1'b0;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    frame_cnt_d    = frame_cnt_q;
`ifdef VGA_PREFETCH_EN
    h_pf_d         = h_pf_q;
    v_pf_d         = v_pf_q;
`endif
    if (tick) begin
      h_d           = h_nxt;
      v_d           = v_nxt;
      hsync_d       = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vsync_d       = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      valid_d       = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      pix_stb_d     = 1'b1;
      line_start_d  = (h_nxt == 10'd0);
      frame_start_d = (h_nxt == 10'd0) && (v_nxt == 10'd0);
      if ((h_nxt == 10'd0) && (v_nxt == 10'd0)) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
`ifdef VGA_PREFETCH_EN
      {v_pf_d, h_pf_d} = advance(v_nxt, h_nxt);
`endif
    end
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= 4'd0;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      valid_q       <= 1'b0;
      pix_stb_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
`ifdef VGA_PREFETCH_EN
      h_pf_q        <= 10'd0;
      v_pf_q        <= 10'd0;
`endif
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      valid_q       <= valid_d;
      pix_stb_q     <= pix_stb_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
`ifdef VGA_PREFETCH_EN
      h_pf_q        <= h_pf_d;
      v_pf_q        <= v_pf_d;
`endif
    end
  end

`ifdef VGA_PREFETCH_EN
  assign h_cnt = h_pf_q;
  assign v_cnt = v_pf_q;
`else
  assign h_cnt = h_q;
  assign v_cnt = v_q;
`endif
  assign pix_stb     = pix_stb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480 timing, a tiny raster for
// whole-frame checks, and a PIX_DIV=1 / active-high sync variant.
`timescale 1ns/1ps
module tb_vga_timing_gen;
`ifdef VGA_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rstA, rstB, rstC;
  logic pixStbA, hsyncA, vsyncA, validA, lineStartA, frameStartA;
  logic pixStbB, hsyncB, vsyncB, validB, lineStartB, frameStartB;
  logic pixStbC, hsyncC, vsyncC, validC, lineStartC, frameStartC;
  logic [9:0] hCntA, vCntA, hCntB, vCntB, hCntC, vCntC;
  logic [15:0] frameCntA, frameCntB, frameCntC;

  vga_timing_gen dutA (
    .clk(clk), .rst(rstA), .pix_stb(pixStbA), .h_cnt(hCntA), .v_cnt(vCntA),
    .hsync(hsyncA), .vsync(vsyncA), .valid(validA), .line_start(lineStartA),
    .frame_start(frameStartA), .frame_cnt(frameCntA)
  );

  // Tiny raster: 15 pixels x 11 lines, hsync [10,13), vsync [7,9).
  vga_timing_gen #(
    .PIX_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(0)
  ) dutB (
    .clk(clk), .rst(rstB), .pix_stb(pixStbB), .h_cnt(hCntB), .v_cnt(vCntB),
    .hsync(hsyncB), .vsync(vsyncB), .valid(validB), .line_start(lineStartB),
    .frame_start(frameStartB), .frame_cnt(frameCntB)
  );

  vga_timing_gen #(.PIX_DIV(1), .SYNC_POL(1)) dutC (
    .clk(clk), .rst(rstC), .pix_stb(pixStbC), .h_cnt(hCntC), .v_cnt(vCntC),
    .hsync(hsyncC), .vsync(vsyncC), .valid(validC), .line_start(lineStartC),
    .frame_start(frameStartC), .frame_cnt(frameCntC)
  );

  task automatic test_reset();
    int early;
    int expH, expV;
    expH = PF ? 0 : 799;
    expV = PF ? 0 : 524;
    rstA = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (hCntA !== 10'(expH)) begin errors++; $display("[TB] FAIL reset_h got %0d expected %0d", hCntA, expH); end
    checks++; if (vCntA !== 10'(expV)) begin errors++; $display("[TB] FAIL reset_v got %0d expected %0d", vCntA, expV); end
    checks++; if ({validA, hsyncA, vsyncA, pixStbA, lineStartA, frameStartA} !== 6'b011000) begin
      errors++; $display("[TB] FAIL reset_flags got %b expected 011000", {validA, hsyncA, vsyncA, pixStbA, lineStartA, frameStartA}); end
    checks++; if (frameCntA !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt got %0d expected 0", frameCntA); end
    rstA = 1'b0;
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (pixStbA || frameStartA || lineStartA) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL first_tick_early got %0d pulses expected 0", early); end
    @(negedge clk);
    checks++; if ({pixStbA, lineStartA, frameStartA, validA} !== 4'b1111) begin
      errors++; $display("[TB] FAIL first_tick_flags got %b expected 1111", {pixStbA, lineStartA, frameStartA, validA}); end
    checks++; if (hCntA !== 10'(PF) || vCntA !== 10'd0) begin
      errors++; $display("[TB] FAIL first_tick_pos got (%0d,%0d) expected (%0d,0)", hCntA, vCntA, PF); end
    checks++; if (frameCntA !== 16'd1) begin errors++; $display("[TB] FAIL first_tick_frame_cnt got %0d expected 1", frameCntA); end
    @(negedge clk);
    checks++; if ({pixStbA, lineStartA, frameStartA} !== 3'b000) begin
      errors++; $display("[TB] FAIL pulse_width got %b expected 000", {pixStbA, lineStartA, frameStartA}); end
  endtask

  task automatic test_line();
    int e = 5;
    int lsEdge = 4;
    int hsCnt = 0, hsFirst = -1, hsLast = -1, validFallH = -1, h0Valid = -1;
    int interval = -1, vAtLs = -1;
    logic prevValid = 1'b1;
    for (int k = 0; k < 3400 && interval < 0; k++) begin
      @(negedge clk);
      e++;
      if (pixStbA) begin
        if (hsyncA == 1'b0) begin
          hsCnt++;
          if (hsFirst < 0) hsFirst = int'(hCntA);
          hsLast = int'(hCntA);
        end
        if (prevValid && !validA && validFallH < 0) validFallH = int'(hCntA);
        prevValid = validA;
        if (hCntA == 10'd0 && h0Valid < 0) h0Valid = int'(validA);
        if (lineStartA) begin
          interval = e - lsEdge;
          vAtLs = int'(vCntA);
        end
      end
    end
    checks++; if (interval !== 3200) begin errors++; $display("[TB] FAIL line_period got %0d expected 3200", interval); end
    checks++; if (vAtLs !== 1) begin errors++; $display("[TB] FAIL line1_v got %0d expected 1", vAtLs); end
    checks++; if (hsCnt !== 96) begin errors++; $display("[TB] FAIL hsync_width got %0d expected 96", hsCnt); end
    checks++; if (hsFirst !== 656 + PF) begin errors++; $display("[TB] FAIL hsync_first_h got %0d expected %0d", hsFirst, 656 + PF); end
    checks++; if (hsLast !== 751 + PF) begin errors++; $display("[TB] FAIL hsync_last_h got %0d expected %0d", hsLast, 751 + PF); end
    checks++; if (validFallH !== 640 + PF) begin errors++; $display("[TB] FAIL valid_fall_h got %0d expected %0d", validFallH, 640 + PF); end
    checks++; if (h0Valid !== (PF ? 0 : 1)) begin errors++; $display("[TB] FAIL valid_at_h0_line1 got %0d expected %0d", h0Valid, PF ? 0 : 1); end
  endtask

  task automatic test_midreset();
    int found = 0;
    int early = 0;
    for (int k = 0; k < 1500 && found == 0; k++) begin
      @(negedge clk);
      if (pixStbA && hCntA == 10'(300 + PF)) found = 1;
    end
    checks++; if (found !== 1) begin errors++; $display("[TB] FAIL midreset_reach got %0d expected 1", found); end
    #1 rstA = 1'b1;
    #1;
    checks++; if (hCntA !== 10'(PF ? 0 : 799) || vCntA !== 10'(PF ? 0 : 524)) begin
      errors++; $display("[TB] FAIL midreset_pos got (%0d,%0d) expected (%0d,%0d)", hCntA, vCntA, PF ? 0 : 799, PF ? 0 : 524); end
    checks++; if ({validA, hsyncA, vsyncA, pixStbA, lineStartA, frameStartA} !== 6'b011000) begin
      errors++; $display("[TB] FAIL midreset_flags got %b expected 011000", {validA, hsyncA, vsyncA, pixStbA, lineStartA, frameStartA}); end
    checks++; if (frameCntA !== 16'd0) begin errors++; $display("[TB] FAIL midreset_frame_cnt got %0d expected 0", frameCntA); end
    @(negedge clk);
    rstA = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pixStbA || frameStartA || lineStartA) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL restart_early got %0d pulses expected 0", early); end
    @(negedge clk);
    checks++; if ({pixStbA, frameStartA, validA} !== 3'b111 || hCntA !== 10'(PF) || vCntA !== 10'd0 || frameCntA !== 16'd1) begin
      errors++; $display("[TB] FAIL restart_first got stb/fs/valid=%b pos=(%0d,%0d) fc=%0d expected 111 (%0d,0) 1",
                         {pixStbA, frameStartA, validA}, hCntA, vCntA, frameCntA, PF); end
  endtask

  task automatic test_frame();
    int e = 0, fsFirst = -1, interval = -1, fc2 = -1, fc1 = -1;
    int validCnt = 0, hsCnt = 0, vsCnt = 0, lsCnt = 0, vsFirstV = -1, hMax = 0, vMax = 0;
    @(negedge clk);
    rstB = 1'b0;
    for (int k = 0; k < 800 && interval < 0; k++) begin
      @(negedge clk);
      e++;
      if (pixStbB) begin
        if (frameStartB && fsFirst >= 0) begin
          interval = e - fsFirst;
          fc2 = int'(frameCntB);
        end else begin
          if (frameStartB) begin
            fsFirst = e;
            fc1 = int'(frameCntB);
          end
          if (fsFirst >= 0) begin
            if (validB) validCnt++;
            if (!hsyncB) hsCnt++;
            if (!vsyncB) begin
              vsCnt++;
              if (vsFirstV < 0) vsFirstV = int'(vCntB);
            end
            if (lineStartB) lsCnt++;
            if (int'(hCntB) > hMax) hMax = int'(hCntB);
            if (int'(vCntB) > vMax) vMax = int'(vCntB);
          end
        end
      end
    end
    checks++; if (fsFirst !== 2) begin errors++; $display("[TB] FAIL small_first_fs_edge got %0d expected 2", fsFirst); end
    checks++; if (fc1 !== 1) begin errors++; $display("[TB] FAIL small_frame_cnt1 got %0d expected 1", fc1); end
    checks++; if (interval !== 330) begin errors++; $display("[TB] FAIL frame_period got %0d expected 330", interval); end
    checks++; if (fc2 !== 2) begin errors++; $display("[TB] FAIL frame_cnt2 got %0d expected 2", fc2); end
    checks++; if (validCnt !== 48) begin errors++; $display("[TB] FAIL frame_valid_ticks got %0d expected 48", validCnt); end
    checks++; if (hsCnt !== 33) begin errors++; $display("[TB] FAIL frame_hsync_ticks got %0d expected 33", hsCnt); end
    checks++; if (vsCnt !== 30) begin errors++; $display("[TB] FAIL frame_vsync_ticks got %0d expected 30", vsCnt); end
    checks++; if (vsFirstV !== 7) begin errors++; $display("[TB] FAIL vsync_first_v got %0d expected 7", vsFirstV); end
    checks++; if (lsCnt !== 11) begin errors++; $display("[TB] FAIL frame_line_starts got %0d expected 11", lsCnt); end
    checks++; if (hMax !== 14 || vMax !== 10) begin errors++; $display("[TB] FAIL frame_max_pos got (%0d,%0d) expected (14,10)", hMax, vMax); end
  endtask

  task automatic test_fast();
    int e = 0, lsFirst = -1, interval = -1, pixZero = 0, hsHigh = 0, hsFirst = -1, vsHigh = 0;
    checks++; if (hsyncC !== 1'b0 || vsyncC !== 1'b0) begin
      errors++; $display("[TB] FAIL fast_reset_sync got %b%b expected 00", hsyncC, vsyncC); end
    @(negedge clk);
    rstC = 1'b0;
    for (int k = 0; k < 1700 && interval < 0; k++) begin
      @(negedge clk);
      e++;
      if (!pixStbC) pixZero++;
      if (lineStartC && lsFirst >= 0) interval = e - lsFirst;
      else begin
        if (lineStartC) lsFirst = e;
        if (lsFirst >= 0) begin
          if (hsyncC) begin
            hsHigh++;
            if (hsFirst < 0) hsFirst = int'(hCntC);
          end
          if (vsyncC) vsHigh++;
        end
      end
    end
    checks++; if (lsFirst !== 1) begin errors++; $display("[TB] FAIL fast_first_ls_edge got %0d expected 1", lsFirst); end
    checks++; if (pixZero !== 0) begin errors++; $display("[TB] FAIL fast_pix_stb_gaps got %0d expected 0", pixZero); end
    checks++; if (interval !== 800) begin errors++; $display("[TB] FAIL fast_line_period got %0d expected 800", interval); end
    checks++; if (hsHigh !== 96) begin errors++; $display("[TB] FAIL fast_hsync_width got %0d expected 96", hsHigh); end
    checks++; if (hsFirst !== 656 + PF) begin errors++; $display("[TB] FAIL fast_hsync_first_h got %0d expected %0d", hsFirst, 656 + PF); end
    checks++; if (vsHigh !== 0) begin errors++; $display("[TB] FAIL fast_vsync_line0 got %0d expected 0", vsHigh); end
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    rstC = 1'b1;
    test_reset();
    test_line();
    test_midreset();
    test_frame();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
